// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for a 3-to-8 one-hot decoder: walks the enabled channels in
// ascending order, with a blanking gap (en low) before each channel's dwell window.
module decoder_scan_ctrl #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               one_shot,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         chan_mask,
  output logic [2:0]         addr,
  output logic               en,
  output logic               step_pulse,
  output logic               frame_done,
  output logic               busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;

  // One counter serves both the blanking gap and the dwell window.
  localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [DWELL_W-1:0] dwell_lat;
  logic [7:0]         mask_lat;
  logic               one_shot_lat;

  logic [2:0]         lowest_in;
  logic [2:0]         lowest_lat;
  logic [2:0]         next_up;
  logic               next_found;
  logic [DWELL_W-1:0] dwell_eff;

  always_comb begin
    lowest_in  = '0;
    lowest_lat = '0;
    next_up    = '0;
    next_found = 1'b0;
    // Descending loops so the last hit is the lowest qualifying channel.
    for (int i = 7; i >= 0; i--) begin
      if (chan_mask[i]) lowest_in = 3'(i);
      if (mask_lat[i]) lowest_lat = 3'(i);
      if (mask_lat[i] && (3'(i) > addr)) begin
        next_found = 1'b1;
        next_up    = 3'(i);
      end
    end
    dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dwell_lat    <= '0;
      mask_lat     <= '0;
      one_shot_lat <= 1'b0;
      addr         <= '0;
      en           <= 1'b0;
      step_pulse   <= 1'b0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop && (chan_mask != '0)) begin
            dwell_lat    <= dwell_eff;
            mask_lat     <= chan_mask;
            one_shot_lat <= one_shot;
            state        <= S_BLANK;
            addr         <= lowest_in;
            en           <= 1'b0;
            busy         <= 1'b1;
            cnt          <= CNT_W'(BLANK_CYCLES - 1);
          end
        end
        S_BLANK: begin
          if (stop) begin
            state <= S_IDLE;
            addr  <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state      <= S_DRIVE;
            en         <= 1'b1;
            step_pulse <= 1'b1;
            cnt        <= CNT_W'(dwell_lat - 1'b1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DRIVE: begin
          if (stop) begin
            state <= S_IDLE;
            addr  <= '0;
            en    <= 1'b0;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            en <= 1'b0;
            if (next_found) begin
              state <= S_BLANK;
              addr  <= next_up;
              cnt   <= CNT_W'(BLANK_CYCLES - 1);
            end else begin
              // Wrapped past the highest enabled channel: frame is complete.
              frame_done <= 1'b1;
              if (one_shot_lat) begin
                state <= S_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= S_BLANK;
                addr  <= lowest_lat;
                cnt   <= CNT_W'(BLANK_CYCLES - 1);
              end
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl; outputs packed as {addr,en,step,frame_done,busy}.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       one_shot = 1'b0;
  logic [7:0] dwell = '0;
  logic [7:0] chan_mask = '0;
  logic [2:0] addr;
  logic       en, step_pulse, frame_done, busy;

  int checks = 0;
  int failures = 0;

  decoder_scan_ctrl #(.DWELL_W(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .one_shot(one_shot),
    .dwell(dwell), .chan_mask(chan_mask), .addr(addr), .en(en),
    .step_pulse(step_pulse), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] vec(input logic [2:0] a, input logic e, input logic s,
                                     input logic f, input logic b);
    return {a, e, s, f, b};
  endfunction

  logic [6:0] obs;
  assign obs = {addr, en, step_pulse, frame_done, busy};

  // Select lines must never move while the decoder is enabled.
  logic       prev_en = 1'b0;
  logic [2:0] prev_addr = '0;
  always @(negedge clk) begin
    if (rst_n && prev_en && en) check("addr_stable", 32'(addr), 32'(prev_addr));
    prev_en   <= en;
    prev_addr <= addr;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    check("stop_idle", 32'(obs), 32'(vec(3'd0, 0, 0, 0, 0)));
  endtask

  initial begin
    logic [2:0] seq2 [3];
    logic [2:0] a;
    int ph, k;
    seq2[0] = 3'd2; seq2[1] = 3'd5; seq2[2] = 3'd7;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", 32'(obs), 32'(vec(3'd0, 0, 0, 0, 0)));
    rst_n = 1'b1;

    // 1: full one-shot frame, dwell 3 -> 5 cycles per channel
    chan_mask = 8'hFF; dwell = 8'd3; one_shot = 1'b1;
    pulse_start();
    for (int c = 1; c <= 44; c++) begin
      ph = (c - 1) % 5;
      a  = 3'((c - 1) / 5);
      if (c <= 40)
        check($sformatf("t1_c%0d", c), 32'(obs), 32'(vec(a, ph >= 2, ph == 2, 0, 1)));
      else if (c == 41)
        check("t1_done", 32'(obs), 32'(vec(3'd7, 0, 0, 1, 0)));
      else
        check($sformatf("t1_idle%0d", c), 32'(obs), 32'(vec(3'd7, 0, 0, 0, 0)));
      @(negedge clk);
    end

    // 2: sparse continuous scan, dwell 1 -> 3 cycles per channel
    chan_mask = 8'b1010_0100; dwell = 8'd1; one_shot = 1'b0;
    pulse_start();
    for (int c = 1; c <= 18; c++) begin
      ph = (c - 1) % 3;
      k  = (c - 1) / 3;
      check($sformatf("t2_c%0d", c), 32'(obs),
            32'(vec(seq2[k % 3], ph == 2, ph == 2, (ph == 0) && (k > 0) && (k % 3 == 0), 1)));
      if (c < 18) @(negedge clk);
    end
    do_stop();

    // 3: dwell 0 treated as 1, single channel 4
    chan_mask = 8'h10; dwell = 8'd0; one_shot = 1'b0;
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      ph = (c - 1) % 3;
      check($sformatf("t3_c%0d", c), 32'(obs),
            32'(vec(3'd4, ph == 2, ph == 2, (ph == 0) && (c > 1), 1)));
      if (c < 12) @(negedge clk);
    end
    do_stop();

    // 4: stop during channel 3 DRIVE, then restart from lowest channel
    chan_mask = 8'hFF; dwell = 8'd3; one_shot = 1'b0;
    pulse_start();
    for (int c = 1; c <= 19; c++) begin
      ph = (c - 1) % 5;
      check($sformatf("t4_c%0d", c), 32'(obs), 32'(vec(3'((c - 1) / 5), ph >= 2, ph == 2, 0, 1)));
      if (c < 19) @(negedge clk);
    end
    do_stop();
    @(negedge clk);
    check("t4_no_fd", 32'(obs), 32'(vec(3'd0, 0, 0, 0, 0)));
    pulse_start();
    check("t4_restart_c1", 32'(obs), 32'(vec(3'd0, 0, 0, 0, 1)));
    repeat (2) @(negedge clk);
    check("t4_restart_c3", 32'(obs), 32'(vec(3'd0, 1, 1, 0, 1)));
    do_stop();

    // 5: ignored starts
    chan_mask = 8'h00; dwell = 8'd1;
    pulse_start();
    check("t5_mask0", 32'(obs), 32'(vec(3'd0, 0, 0, 0, 0)));
    @(negedge clk);
    check("t5_mask0_b", 32'(obs), 32'(vec(3'd0, 0, 0, 0, 0)));
    chan_mask = 8'hFF; stop = 1'b1; start = 1'b1;
    @(negedge clk) begin start = 1'b0; stop = 1'b0; end
    check("t5_start_stop", 32'(obs), 32'(vec(3'd0, 0, 0, 0, 0)));
    @(negedge clk);
    check("t5_start_stop_b", 32'(obs), 32'(vec(3'd0, 0, 0, 0, 0)));
    chan_mask = 8'h03; dwell = 8'd1; one_shot = 1'b1;
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      ph = (c - 1) % 3;
      if (c <= 6)
        check($sformatf("t5_c%0d", c), 32'(obs), 32'(vec(3'((c - 1) / 3), ph == 2, ph == 2, 0, 1)));
      else
        check($sformatf("t5_c%0d", c), 32'(obs), 32'(vec(3'd1, 0, 0, c == 7, 0)));
      if (c == 2) begin start = 1'b1; chan_mask = 8'h80; dwell = 8'd5; one_shot = 1'b0; end
      if (c == 3) start = 1'b0;
      @(negedge clk);
    end

    // 6: asynchronous reset in the middle of BLANK
    chan_mask = 8'h40; dwell = 8'd2; one_shot = 1'b0;
    pulse_start();
    check("t6_blank", 32'(obs), 32'(vec(3'd6, 0, 0, 0, 1)));
    #2 rst_n = 1'b0;
    #1 check("t6_async", 32'(obs), 32'(vec(3'd0, 0, 0, 0, 0)));
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("t6_idle%0d", c), 32'(obs), 32'(vec(3'd0, 0, 0, 0, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
